// File: rtl/pipe_stage_skid.sv
// Pipeline-boundary register with a 2-entry skid buffer under a valid/ready handshake.
// Every output is registered, so there is no combinational path from in_* to out_* or from out_ready to in_ready.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W     = 165,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [DATA_W-1:0] main_r;
  logic [DATA_W-1:0] main_nxt_s;
  logic [DATA_W-1:0] skid_r;
  logic [DATA_W-1:0] skid_nxt_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [1:0]        occ_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              in_fire_s;
  logic              out_fire_s;

  function automatic logic [1:0] occ_of(input state_t st);
    case (st)
      ST_EMPTY: occ_of = 2'd0;
      ST_ONE:   occ_of = 2'd1;
      ST_TWO:   occ_of = 2'd2;
      default:  occ_of = 2'd0;
    endcase
  endfunction

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // Next-state and next-payload selection; flush overrides the handshake.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      main_nxt_s  = BUBBLE_VAL;
      skid_nxt_s  = BUBBLE_VAL;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_nxt_s  = in_data;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_nxt_s  = in_data;
            state_nxt_s = ST_ONE;
          end else if (in_fire_s) begin
            skid_nxt_s  = in_data;
            state_nxt_s = ST_TWO;
          end else if (out_fire_s) begin
            main_nxt_s  = BUBBLE_VAL;
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the downstream side can move.
          if (out_fire_s) begin
            main_nxt_s  = skid_r;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          main_nxt_s  = BUBBLE_VAL;
          skid_nxt_s  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // State, payload registers, registered handshake outputs and the saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      main_r      <= BUBBLE_VAL;
      skid_r      <= BUBBLE_VAL;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occ_r       <= 2'd0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_TWO);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      occ_r       <= occ_of(state_nxt_s);
      if (out_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = occ_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random bench for pipe_stage_skid: a queue holds the beats the stage should be carrying,
// and every cycle the DUT outputs are compared against that queue and a saturating stall model.
module tb_pipe_stage_skid;

  localparam int          DW  = 16;
  localparam int          CW  = 4;
  localparam logic [15:0] BUB = 16'hBEEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb[$];
  int            exp_stall = 0;
  bit            model_on = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: compare outputs with the model, update the model from this cycle's handshake, then advance.
  task automatic cycle();
    bit            ofire;
    bit            ifire;
    logic [DW-1:0] head;
    if (model_on) begin
      check("occupancy", 32'(occupancy), 32'(sb.size()));
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      if (sb.size() == 0) check("bubble", 32'(out_data), 32'(BUB));
      check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    end
    ofire = (sb.size() != 0) && out_ready;
    ifire = in_valid && (sb.size() < 2);
    if (reset) begin
      sb.delete();
      exp_stall = 0;
    end else begin
      if ((sb.size() != 0) && !out_ready && (exp_stall < 15)) exp_stall++;
      if (ofire) begin
        head = sb.pop_front();
        if (model_on) check("out_data", 32'(out_data), 32'(head));
      end
      if (flush) sb.delete();
      else if (ifire) sb.push_back(in_data);
    end
    @(posedge clk);
    #1;
    if (reset) model_on = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'(BUB));
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);

    // T1 streaming
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 16'(i);
      cycle();
      check("t1_data", 32'(out_data), 32'(i));
      check("t1_occ", 32'(occupancy), 32'd1);
      check("t1_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    cycle();

    // T2 skid fill and drain
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A;
    cycle();
    check("t2_occ1", 32'(occupancy), 32'd1);
    check("t2_rdy1", 32'(in_ready), 32'd1);
    in_data = 16'h000B;
    cycle();
    check("t2_occ2", 32'(occupancy), 32'd2);
    check("t2_rdy0", 32'(in_ready), 32'd0);
    check("t2_hold", 32'(out_data), 32'h000A);
    in_valid = 1'b0;
    cycle();
    check("t2_stable", 32'(out_data), 32'h000A);
    out_ready = 1'b1;
    cycle();
    check("t2_second", 32'(out_data), 32'h000B);
    check("t2_rdy_back", 32'(in_ready), 32'd1);
    cycle();
    check("t2_empty", 32'(out_valid), 32'd0);
    check("t2_bubble", 32'(out_data), 32'(BUB));

    // T3 flush with a beat offered in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A;
    cycle();
    in_data = 16'h000B;
    cycle();
    in_data = 16'h000C; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("t3_valid", 32'(out_valid), 32'd0);
    check("t3_data", 32'(out_data), 32'(BUB));
    check("t3_occ", 32'(occupancy), 32'd0);
    check("t3_rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t3_no_c", 32'(out_valid), 32'd0);
    end

    // T4 stall counter saturation
    reset = 1'b1;
    cycle();
    reset = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0007;
    cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    check("t4_sat", 32'(stall_cnt), 32'd15);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("t4_flush_keeps", 32'(stall_cnt), 32'd15);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t4_reset_clears", 32'(stall_cnt), 32'd0);

    // T5 reset mid-operation
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00A1;
    cycle();
    in_data = 16'h00B2;
    cycle();
    out_ready = 1'b1; in_valid = 1'b0;
    cycle();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00D4;
    cycle();
    check("t5_occ2", 32'(occupancy), 32'd2);
    out_ready = 1'b1; in_valid = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_rdy", 32'(in_ready), 32'd1);
    check("t5_data", 32'(out_data), 32'(BUB));
    check("t5_occ", 32'(occupancy), 32'd0);
    check("t5_stall", 32'(stall_cnt), 32'd0);
    in_valid = 1'b1; in_data = 16'h0005; out_ready = 1'b0;
    cycle();
    check("t5_new_valid", 32'(out_valid), 32'd1);
    check("t5_new_data", 32'(out_data), 32'h0005);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    check("t5_drained", 32'(out_valid), 32'd0);

    // T6 random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_data   = 16'($urandom);
      cycle();
      if (errors > 20) break;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    check("t6_drained", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
